// File: rtl/cska_pipe.sv
// Pipelined carry-skip adder/subtractor: BLOCK-bit ripple groups with skip muxes, spread over STAGES register stages.
// Latency STAGES cycles; global stall (en = ~out_valid | out_ready) holds every stage, so in_ready drops while the output is blocked.
module cska_pipe #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = (BLOCK > 0) ? WIDTH / BLOCK : 1;
  localparam int G  = (STAGES > 0) ? NG / STAGES : 1;
  localparam int SW = G * BLOCK;
  localparam bit LEGAL = (WIDTH > 0) && (BLOCK > 0) && (STAGES > 0) &&
                         ((WIDTH % ((BLOCK > 0) ? BLOCK : 1)) == 0) &&
                         ((NG % ((STAGES > 0) ? STAGES : 1)) == 0);

  if (!LEGAL) begin : g_param_check
    $error("cska_pipe: WIDTH must split into BLOCK-bit groups spread evenly over STAGES");
  end

  logic             en;
  logic [WIDTH-1:0] b_cond;
  logic             c0;

  always_comb begin
    en       = ~out_valid | out_ready;
    in_ready = en & ~reset;
    b_cond   = sub ? ~b : b;
    c0       = sub | cin;
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int  LO   = s * SW;
    localparam int  RW   = WIDTH - LO;  // operand bits not yet consumed when entering this stage
    localparam bit  LAST = (s == STAGES - 1);

    logic [RW-1:0]      a_rem, b_rem;
    logic               c_in, v_in;
    logic [SW-1:0]      slice;
    logic [LO+SW-1:0]   sum_d, sum_q;
    logic               c_d, c_q, v_d, v_q;
    logic [SW-1:0]      aa, bb;
    logic               c, rc, p, pb;

    if (s == 0) begin : g_src
      always_comb begin
        a_rem = a;
        b_rem = b_cond;
        c_in  = c0;
        v_in  = in_valid;
        sum_d = slice;
      end
    end else begin : g_src
      always_comb begin
        a_rem = g_stage[s-1].g_hi.a_q;
        b_rem = g_stage[s-1].g_hi.b_q;
        c_in  = g_stage[s-1].c_q;
        v_in  = g_stage[s-1].v_q;
        sum_d = {slice, g_stage[s-1].sum_q};
      end
    end

    // Bits are consumed LSB-first by shifting; each group ends in its skip mux.
    always_comb begin
      aa    = a_rem[SW-1:0];
      bb    = b_rem[SW-1:0];
      slice = '0;
      c     = c_in;
      rc    = 1'b0;
      p     = 1'b0;
      pb    = 1'b0;
      for (int g = 0; g < G; g++) begin
        rc = c;
        p  = 1'b1;
        for (int k = 0; k < BLOCK; k++) begin
          pb            = aa[0] ^ bb[0];
          slice         = slice >> 1;
          slice[SW-1]   = pb ^ rc;
          p             = p & pb;
          rc            = (aa[0] & bb[0]) | (pb & rc);
          aa            = aa >> 1;
          bb            = bb >> 1;
        end
        c = rc | (p & c);
      end
      c_d = c;
      v_d = v_in;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        sum_q <= '0;
        c_q   <= 1'b0;
        v_q   <= 1'b0;
      end else if (en) begin
        sum_q <= sum_d;
        c_q   <= c_d;
        v_q   <= v_d;
      end
    end

    if (!LAST) begin : g_hi
      logic [RW-SW-1:0] a_d, a_q, b_d, b_q;
      always_comb begin
        a_d = a_rem[RW-1:SW];
        b_d = b_rem[RW-1:SW];
      end
      always_ff @(posedge clk) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_msb
      logic cm_d, cm_q;
      // Carry into the MSB recovered from its sum bit and operands.
      always_comb cm_d = a_rem[SW-1] ^ b_rem[SW-1] ^ slice[SW-1];
      always_ff @(posedge clk) begin
        if (reset)   cm_q <= 1'b0;
        else if (en) cm_q <= cm_d;
      end
    end
  end

  always_comb begin
    sum       = g_stage[STAGES-1].sum_q;
    cout      = g_stage[STAGES-1].c_q;
    out_valid = g_stage[STAGES-1].v_q;
    ovf       = g_stage[STAGES-1].g_msb.cm_q ^ g_stage[STAGES-1].c_q;
  end

endmodule
